// File: rtl/seg_scan_ctrl_pkg.sv
// seg_pkg: shared definitions for the multiplexed 7-segment scanner.
//   SEG_x     : 8-bit segment patterns, [7:1] = a..g, [0] = dp (always 0 here).
//   SEG_BLANK : all segments off.
//   state_t   : scan FSM state encoding.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'b1111_1100;
  localparam logic [7:0] SEG_1     = 8'b0110_0000;
  localparam logic [7:0] SEG_2     = 8'b1101_1010;
  localparam logic [7:0] SEG_3     = 8'b1111_0010;
  localparam logic [7:0] SEG_4     = 8'b0110_0110;
  localparam logic [7:0] SEG_5     = 8'b1011_0110;
  localparam logic [7:0] SEG_6     = 8'b1011_1110;
  localparam logic [7:0] SEG_7     = 8'b1110_0000;
  localparam logic [7:0] SEG_8     = 8'b1111_1110;
  localparam logic [7:0] SEG_9     = 8'b1111_0110;
  localparam logic [7:0] SEG_A     = 8'b1110_1110;
  localparam logic [7:0] SEG_B     = 8'b0011_1110;
  localparam logic [7:0] SEG_C     = 8'b1001_1100;
  localparam logic [7:0] SEG_D     = 8'b0111_1010;
  localparam logic [7:0] SEG_E     = 8'b1001_1110;
  localparam logic [7:0] SEG_F     = 8'b1000_1110;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: application/display-side signal bundle of the scanner.
//   data, dp_in, digit_en, lz_suppress, load : driven by the application (master).
//   seg_o, sig_o, frame_o                    : driven by the scanner (slave).
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 8
);

  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   digit_en;
  logic                lz_suppress;
  logic                load;
  logic [7:0]          seg_o;
  logic [DIGITS-1:0]   sig_o;
  logic                frame_o;

  modport master (
    output data, dp_in, digit_en, lz_suppress, load,
    input  seg_o, sig_o, frame_o
  );

  modport slave (
    input  data, dp_in, digit_en, lz_suppress, load,
    output seg_o, sig_o, frame_o
  );

endinterface

// File: rtl/seg_scan_ctrl_decode.sv
// seg_decode: combinational 4-bit code to 7-segment glyph (a..g, MSB = a).
//   code  : digit code 0..F.
//   glyph : segment pattern; codes A-F give all-off unless HEX_EN != 0.
module seg_decode
  import seg_pkg::*;
#(
  parameter int HEX_EN = 1
) (
  input  logic [3:0] code,
  output logic [6:0] glyph
);

  localparam bit HEX_ON = (HEX_EN != 0);

  always_comb begin
    glyph = SEG_BLANK[7:1];
    case (code)
      4'h0: glyph = SEG_0[7:1];
      4'h1: glyph = SEG_1[7:1];
      4'h2: glyph = SEG_2[7:1];
      4'h3: glyph = SEG_3[7:1];
      4'h4: glyph = SEG_4[7:1];
      4'h5: glyph = SEG_5[7:1];
      4'h6: glyph = SEG_6[7:1];
      4'h7: glyph = SEG_7[7:1];
      4'h8: glyph = SEG_8[7:1];
      4'h9: glyph = SEG_9[7:1];
      4'hA: glyph = HEX_ON ? SEG_A[7:1] : SEG_BLANK[7:1];
      4'hB: glyph = HEX_ON ? SEG_B[7:1] : SEG_BLANK[7:1];
      4'hC: glyph = HEX_ON ? SEG_C[7:1] : SEG_BLANK[7:1];
      4'hD: glyph = HEX_ON ? SEG_D[7:1] : SEG_BLANK[7:1];
      4'hE: glyph = HEX_ON ? SEG_E[7:1] : SEG_BLANK[7:1];
      4'hF: glyph = HEX_ON ? SEG_F[7:1] : SEG_BLANK[7:1];
      default: glyph = SEG_BLANK[7:1];
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment display scanner.
//   clk   : system clock, rising edge.
//   rst_n : asynchronous active-low reset.
//   bus   : slave side of seg_scan_ctrl_if (digit codes, dp, enables,
//           lz_suppress, load in; registered seg_o / sig_o / frame_o out).
// Each digit is preceded by BLANK all-off cycles and then driven for DWELL
// cycles; a frame is DIGITS*(DWELL+BLANK) cycles. Displayed values come only
// from the shadow registers, refreshed at the frame boundary.
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_BLANK | all selects off, segments off, anti-ghosting gap
// ST_SHOW  | digit idx selected, glyph from shadow nibble idx
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DWELL  = 50000,
  parameter int BLANK  = 500,
  parameter int HEX_EN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(DIGITS);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK > 0) ? BLANK - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam state_t        ST_INIT    = (BLANK > 0) ? ST_BLANK : ST_SHOW;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [IW-1:0]       idx, idx_nxt;

  logic [4*DIGITS-1:0] shadow_data;
  logic [DIGITS-1:0]   shadow_dp;
  logic                pending;

  logic                boundary;
  logic                capture;
  logic [4*DIGITS-1:0] eff_data;
  logic [DIGITS-1:0]   eff_dp;
  logic [DIGITS-1:0]   lz_blank;
  logic [3:0]          cur_code;
  logic [6:0]          cur_glyph;
  logic [7:0]          seg_nxt;
  logic [DIGITS-1:0]   sig_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    case (state)
      ST_BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_nxt = ST_SHOW;
          cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt == DWELL_LAST) begin
          state_nxt = (BLANK > 0) ? ST_BLANK : ST_SHOW;
          cnt_nxt   = '0;
          idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  // First SHOW cycle of digit 0: the snapshot point of every frame.
  assign boundary = (state == ST_SHOW) && (idx == '0) && (cnt == '0);
  assign capture  = boundary && (pending || bus.load);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      pending     <= 1'b1;
    end else begin
      if (capture) begin
        shadow_data <= bus.data;
        shadow_dp   <= bus.dp_in;
      end
      if (boundary) begin
        pending <= 1'b0;
      end else if (bus.load) begin
        pending <= 1'b1;
      end
    end
  end

  // The output register of the boundary cycle must already show the newly
  // sampled values, so bypass the shadow while it is being written.
  assign eff_data = capture ? bus.data  : shadow_data;
  assign eff_dp   = capture ? bus.dp_in : shadow_dp;

  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_blank = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      all_zero    = all_zero && (eff_data[4*k +: 4] == 4'h0);
      lz_blank[k] = bus.lz_suppress && all_zero;
    end
  end

  assign cur_code = eff_data[{idx, 2'b00} +: 4];

  seg_decode #(
    .HEX_EN (HEX_EN)
  ) u_decode (
    .code  (cur_code),
    .glyph (cur_glyph)
  );

  always_comb begin
    seg_nxt = SEG_BLANK;
    sig_nxt = '1;
    if (state == ST_SHOW) begin
      seg_nxt      = {(lz_blank[idx] ? 7'h00 : cur_glyph), eff_dp[idx]};
      sig_nxt[idx] = ~bus.digit_en[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.seg_o   <= SEG_BLANK;
      bus.sig_o   <= '1;
      bus.frame_o <= 1'b0;
    end else begin
      bus.seg_o   <= seg_nxt;
      bus.sig_o   <= sig_nxt;
      bus.frame_o <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: two scanner instances (DIGITS=4, DWELL=4) sharing stimulus:
//   index 0: BLANK=2, HEX_EN=1    index 1: BLANK=0, HEX_EN=0
// Expected outputs come from a frame-position model: each cycle's output is
// derived from (cycles since reset) mod frame length and the snapshot rules.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DWELL  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] st_data;
  logic [3:0]  st_dp;
  logic [3:0]  st_en;
  logic        st_lz;
  logic        st_load;

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus_a ();
  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus_b ();

  assign bus_a.data        = st_data;
  assign bus_a.dp_in       = st_dp;
  assign bus_a.digit_en    = st_en;
  assign bus_a.lz_suppress = st_lz;
  assign bus_a.load        = st_load;
  assign bus_b.data        = st_data;
  assign bus_b.dp_in       = st_dp;
  assign bus_b.digit_en    = st_en;
  assign bus_b.lz_suppress = st_lz;
  assign bus_b.load        = st_load;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(2), .HEX_EN(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  seg_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(0), .HEX_EN(0)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  logic [6:0] glyph_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  int blank_of [2] = '{2, 0};
  int hex_of   [2] = '{1, 0};

  int          n;
  logic [15:0] sh_data [2];
  logic [3:0]  sh_dp   [2];
  bit          pend    [2];
  logic [7:0]  exp_seg [2];
  logic [3:0]  exp_sig [2];
  bit          exp_frame [2];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void model_reset();
    n = 0;
    for (int i = 0; i < 2; i++) begin
      sh_data[i] = 16'h0;
      sh_dp[i]   = 4'h0;
      pend[i]    = 1'b1;
    end
  endfunction

  // Predicts what the outputs will hold after the coming clock edge.
  function automatic void model_step();
    for (int i = 0; i < 2; i++) begin
      int          per, pos, d, w;
      bit          show, bnd, supp;
      logic [15:0] ed;
      logic [3:0]  edp;
      logic [3:0]  code;
      logic [6:0]  g;
      per  = DWELL + blank_of[i];
      pos  = n % (DIGITS * per);
      d    = pos / per;
      w    = pos % per;
      show = (w >= blank_of[i]);
      bnd  = (pos == blank_of[i]);
      ed   = sh_data[i];
      edp  = sh_dp[i];
      if (bnd && (pend[i] || st_load)) begin
        ed  = st_data;
        edp = st_dp;
      end
      if (bnd) begin
        sh_data[i] = ed;
        sh_dp[i]   = edp;
        pend[i]    = 1'b0;
      end else if (st_load) begin
        pend[i] = 1'b1;
      end
      exp_frame[i] = bnd;
      exp_sig[i]   = 4'hF;
      exp_seg[i]   = 8'h00;
      if (show) begin
        code = ed[4*d +: 4];
        g    = (code > 4'h9 && hex_of[i] == 0) ? 7'h00 : glyph_tab[code];
        supp = st_lz && (d > 0) && ((ed >> (4*d)) == 16'h0);
        if (supp) g = 7'h00;
        exp_seg[i]    = {g, edp[d]};
        exp_sig[i][d] = ~st_en[d];
      end
    end
    n++;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, n, obs, expv);
    end
  endtask

  task automatic check_all();
    check("a_seg",   bus_a.seg_o,            exp_seg[0]);
    check("a_sig",   {4'h0, bus_a.sig_o},    {4'h0, exp_sig[0]});
    check("a_frame", {7'h0, bus_a.frame_o},  {7'h0, exp_frame[0]});
    check("b_seg",   bus_b.seg_o,            exp_seg[1]);
    check("b_sig",   {4'h0, bus_b.sig_o},    {4'h0, exp_sig[1]});
    check("b_frame", {7'h0, bus_b.frame_o},  {7'h0, exp_frame[1]});
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_a_seg"},   bus_a.seg_o,           8'h00);
    check({tag, "_a_sig"},   {4'h0, bus_a.sig_o},   8'h0F);
    check({tag, "_a_frame"}, {7'h0, bus_a.frame_o}, 8'h00);
    check({tag, "_b_seg"},   bus_b.seg_o,           8'h00);
    check({tag, "_b_sig"},   {4'h0, bus_b.sig_o},   8'h0F);
    check({tag, "_b_frame"}, {7'h0, bus_b.frame_o}, 8'h00);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) tick();
  endtask

  task automatic pulse_load();
    st_load = 1'b1;
    tick();
    st_load = 1'b0;
  endtask

  initial begin
    st_data = 16'h0;
    st_dp   = 4'h0;
    st_en   = 4'hF;
    st_lz   = 1'b0;
    st_load = 1'b0;
    model_reset();

    #12;
    reset_check("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic scan of 1234 with a load on the first cycle.
    st_data = 16'h1234;
    pulse_load();
    run(60);

    // Mid-frame update: current frame keeps the old snapshot.
    run(9);
    st_data = 16'h5678;
    pulse_load();
    run(60);

    // Leading-zero suppression with dp on a suppressed digit.
    st_lz   = 1'b1;
    st_data = 16'h0005;
    st_dp   = 4'b0100;
    pulse_load();
    run(50);
    st_data = 16'h0000;
    st_dp   = 4'b0000;
    pulse_load();
    run(50);

    // Hex codes: glyphs on instance 0, blank on instance 1.
    st_lz   = 1'b0;
    st_data = 16'hABCD;
    pulse_load();
    run(50);

    // Disabled digits keep their selects high.
    st_en = 4'b1010;
    run(50);
    st_en = 4'hF;
    run(10);

    // Randomized traffic, biased toward leading zeros.
    for (int k = 0; k < 400; k++) begin
      st_data = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      st_dp   = 4'($urandom);
      st_load = ($urandom_range(0, 7) == 0);
      if ((k % 16) == 0) st_en = 4'($urandom);
      if ((k % 20) == 0) st_lz = 1'($urandom);
      tick();
    end
    st_load = 1'b0;
    st_en   = 4'hF;
    st_lz   = 1'b0;

    // Asynchronous reset while a digit is being shown.
    st_data = 16'h4321;
    st_dp   = 4'b0001;
    for (int k = 0; k < 12 && exp_sig[0] == 4'hF; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    reset_check("rst_async");
    model_reset();
    @(posedge clk);
    #1;
    reset_check("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    run(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
